// File: rtl/immediate_instruction_encoder_if.sv
// ============================================================================
// immediate_instruction_encoder_if
// Request / encoded-word stream bundle for the immediate instruction encoder.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface immediate_instruction_encoder_if #(
    parameter int SIZE = 32
);
    logic            req_valid;
    logic            req_ready;
    logic [2:0]      req_fmt;
    logic [6:0]      req_opcode;
    logic [2:0]      req_funct3;
    logic [4:0]      req_rd;
    logic [4:0]      req_rs1;
    logic [4:0]      req_rs2;
    logic [SIZE-1:0] req_imm;
    logic            instr_valid;
    logic            instr_ready;
    logic [SIZE-1:0] instr_out;
    logic            instr_last;
    logic            err;

    modport master (
        output req_valid, req_fmt, req_opcode, req_funct3, req_rd, req_rs1,
               req_rs2, req_imm, instr_ready,
        input  req_ready, instr_valid, instr_out, instr_last, err
    );

    modport slave (
        input  req_valid, req_fmt, req_opcode, req_funct3, req_rd, req_rs1,
               req_rs2, req_imm, instr_ready,
        output req_ready, instr_valid, instr_out, instr_last, err
    );
endinterface

`default_nettype wire

// File: rtl/immediate_instruction_encoder.sv
// ============================================================================
// immediate_instruction_encoder
// Encodes field-level requests into RV32I words; optional IMM_ENC_LI_EN adds
// the LI (LUI/ADDI) constant-load expansion.
// Revision: 1.0
// ============================================================================
`default_nettype none

module immediate_instruction_encoder #(
    parameter int SIZE = 32
) (
    input  wire logic                    clk,
    input  wire logic                    reset,
    immediate_instruction_encoder_if.slave bus
);
    localparam logic [2:0] C_FMT_I  = 3'd0;
    localparam logic [2:0] C_FMT_S  = 3'd1;
    localparam logic [2:0] C_FMT_B  = 3'd2;
    localparam logic [2:0] C_FMT_U  = 3'd3;
    localparam logic [2:0] C_FMT_J  = 3'd4;
`ifdef IMM_ENC_LI_EN
    localparam logic [2:0] C_FMT_LI = 3'd5;
    localparam logic [6:0] C_OP_OPIMM = 7'b0010011;
    localparam logic [6:0] C_OP_LUI   = 7'b0110111;
`endif

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EMIT_LO = 2'd1,
        HOLD    = 2'd2
    } state_t;

    state_t          r_state;
    logic            r_valid;
    logic [SIZE-1:0] r_out;
    logic            r_err;
`ifdef IMM_ENC_LI_EN
    logic            r_last;
    logic [SIZE-1:0] r_pending;
    logic            w_pair;
    logic [SIZE-1:0] w_lo_word;
    logic [19:0]     w_hi;
`endif

    logic [SIZE-1:0] w_word;
    logic            w_bad;
    logic            w_fit12;
    logic            w_fit13;
    logic            w_fit21;
    logic            w_accept;
    logic            w_out_hs;
    logic [31:0]     w_imm;
    logic [4:0]      w_rd;
    logic [4:0]      w_rs1;
    logic [4:0]      w_rs2;
    logic [2:0]      w_f3;
    logic [6:0]      w_op;

    assign w_imm = bus.req_imm;
    assign w_rd  = bus.req_rd;
    assign w_rs1 = bus.req_rs1;
    assign w_rs2 = bus.req_rs2;
    assign w_f3  = bus.req_funct3;
    assign w_op  = bus.req_opcode;

    // A value fits N signed bits when all bits above N-1 equal the sign bit.
    assign w_fit12 = (&w_imm[31:11]) | ~(|w_imm[31:11]);
    assign w_fit13 = (&w_imm[31:12]) | ~(|w_imm[31:12]);
    assign w_fit21 = (&w_imm[31:20]) | ~(|w_imm[31:20]);

`ifdef IMM_ENC_LI_EN
    // Adding 0x800 carries into bit 12 exactly when imm[11] is set.
    assign w_hi = w_imm[31:12] + {19'd0, w_imm[11]};
`endif

    always_comb begin
        w_word = '0;
        w_bad  = 1'b0;
`ifdef IMM_ENC_LI_EN
        w_pair    = 1'b0;
        w_lo_word = '0;
`endif
        case (bus.req_fmt)
            C_FMT_I: begin
                w_word = {w_imm[11:0], w_rs1, w_f3, w_rd, w_op};
                w_bad  = ~w_fit12;
            end
            C_FMT_S: begin
                w_word = {w_imm[11:5], w_rs2, w_rs1, w_f3, w_imm[4:0], w_op};
                w_bad  = ~w_fit12;
            end
            C_FMT_B: begin
                w_word = {w_imm[12], w_imm[10:5], w_rs2, w_rs1, w_f3,
                          w_imm[4:1], w_imm[11], w_op};
                w_bad  = ~w_fit13 | w_imm[0];
            end
            C_FMT_U: begin
                w_word = {w_imm[31:12], w_rd, w_op};
                w_bad  = |w_imm[11:0];
            end
            C_FMT_J: begin
                w_word = {w_imm[20], w_imm[10:1], w_imm[11], w_imm[19:12],
                          w_rd, w_op};
                w_bad  = ~w_fit21 | w_imm[0];
            end
`ifdef IMM_ENC_LI_EN
            C_FMT_LI: begin
                if (w_fit12) begin
                    w_word = {w_imm[11:0], 5'd0, 3'b000, w_rd, C_OP_OPIMM};
                end else begin
                    w_word    = {w_hi, w_rd, C_OP_LUI};
                    w_lo_word = {w_imm[11:0], w_rd, 3'b000, w_rd, C_OP_OPIMM};
                    w_pair    = |w_imm[11:0];
                end
            end
`endif
            default: w_bad = 1'b1;
        endcase
    end

    assign bus.req_ready = ~reset & (r_state == IDLE) & (~r_valid | bus.instr_ready);
    assign w_accept      = bus.req_valid & bus.req_ready;
    assign w_out_hs      = r_valid & bus.instr_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
            r_out   <= '0;
            r_err   <= 1'b0;
`ifdef IMM_ENC_LI_EN
            r_last    <= 1'b0;
            r_pending <= '0;
`endif
        end else begin
            r_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (w_bad) begin
                            r_err   <= 1'b1;
                            r_valid <= 1'b0;
                        end else begin
                            r_valid <= 1'b1;
                            r_out   <= w_word;
`ifdef IMM_ENC_LI_EN
                            r_last  <= ~w_pair;
                            if (w_pair) begin
                                r_pending <= w_lo_word;
                                r_state   <= EMIT_LO;
                            end
`endif
                        end
                    end else if (w_out_hs) begin
                        r_valid <= 1'b0;
                    end
                end
`ifdef IMM_ENC_LI_EN
                EMIT_LO: begin
                    if (w_out_hs) begin
                        r_out   <= r_pending;
                        r_last  <= 1'b1;
                        r_state <= IDLE;
                    end
                end
`endif
                default: begin
                    r_valid <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.instr_valid = r_valid;
    assign bus.instr_out   = r_out;
    assign bus.err         = r_err;
`ifdef IMM_ENC_LI_EN
    assign bus.instr_last  = r_last;
`else
    assign bus.instr_last  = r_valid;
`endif

endmodule

`default_nettype wire

// File: tb/tb_immediate_instruction_encoder.sv
// ============================================================================
// tb_immediate_instruction_encoder
// Directed vector table plus hand-written backpressure / LI / reset sequences.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_immediate_instruction_encoder;
    logic clk;
    logic reset;
    int   total;
    int   bad;

    immediate_instruction_encoder_if bus ();

    immediate_instruction_encoder dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  fmt;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic        err;
        logic [31:0] word;
    } vec_t;

    localparam int NV = 21;
    vec_t vecs [NV];

`ifdef IMM_ENC_LI_EN
    localparam logic LI_ON = 1'b1;
`else
    localparam logic LI_ON = 1'b0;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.req_fmt    = v.fmt;
        bus.req_opcode = v.op;
        bus.req_funct3 = v.f3;
        bus.req_rd     = v.rd;
        bus.req_rs1    = v.rs1;
        bus.req_rs2    = v.rs2;
        bus.req_imm    = v.imm;
        bus.req_valid  = 1'b1;
    endtask

    task automatic check_out(input vec_t v, input string tag);
        check({tag, ".valid"}, {31'd0, bus.instr_valid}, {31'd0, ~v.err});
        check({tag, ".err"},   {31'd0, bus.err},         {31'd0, v.err});
        if (!v.err) begin
            check({tag, ".word"}, bus.instr_out,              v.word);
            check({tag, ".last"}, {31'd0, bus.instr_last},    32'd1);
        end
    endtask

    vec_t v_li2;
    vec_t v_j;
    vec_t v_u;

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        bus.req_valid   = 1'b0;
        bus.req_fmt     = '0;
        bus.req_opcode  = '0;
        bus.req_funct3  = '0;
        bus.req_rd      = '0;
        bus.req_rs1     = '0;
        bus.req_rs2     = '0;
        bus.req_imm     = '0;
        bus.instr_ready = 1'b1;

        //            fmt   op        f3    rd    rs1   rs2   imm            err  word
        vecs[0]  = '{3'd0, 7'h13, 3'd0, 5'd3, 5'd2, 5'd0, 32'hFFFFFFFF, 1'b0, 32'hFFF10193};
        vecs[1]  = '{3'd0, 7'h03, 3'd2, 5'd4, 5'd1, 5'd0, 32'd2047,     1'b0, 32'h7FF0A203};
        vecs[2]  = '{3'd0, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 32'd2048,     1'b1, 32'h0};
        vecs[3]  = '{3'd0, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 32'hFFFFF800, 1'b0, 32'h80000093};
        vecs[4]  = '{3'd1, 7'h23, 3'd2, 5'd0, 5'd2, 5'd5, 32'd20,       1'b0, 32'h00512A23};
        vecs[5]  = '{3'd1, 7'h23, 3'd2, 5'd0, 5'd2, 5'd5, 32'hFFFFF7FF, 1'b1, 32'h0};
        vecs[6]  = '{3'd2, 7'h63, 3'd1, 5'd0, 5'd5, 5'd6, 32'hFFFFFFF8, 1'b0, 32'hFE629CE3};
        vecs[7]  = '{3'd2, 7'h63, 3'd0, 5'd0, 5'd1, 5'd2, 32'd4094,     1'b0, 32'h7E208FE3};
        vecs[8]  = '{3'd2, 7'h63, 3'd0, 5'd0, 5'd1, 5'd2, 32'd4096,     1'b1, 32'h0};
        vecs[9]  = '{3'd2, 7'h63, 3'd0, 5'd0, 5'd1, 5'd2, 32'd5,        1'b1, 32'h0};
        vecs[10] = '{3'd3, 7'h37, 3'd0, 5'd5, 5'd0, 5'd0, 32'hABCDE000, 1'b0, 32'hABCDE2B7};
        vecs[11] = '{3'd3, 7'h37, 3'd0, 5'd5, 5'd0, 5'd0, 32'h00001001, 1'b1, 32'h0};
        vecs[12] = '{3'd4, 7'h6F, 3'd0, 5'd1, 5'd0, 5'd0, 32'd2048,     1'b0, 32'h001000EF};
        vecs[13] = '{3'd4, 7'h6F, 3'd0, 5'd1, 5'd0, 5'd0, 32'd3,        1'b1, 32'h0};
        vecs[14] = '{3'd4, 7'h6F, 3'd0, 5'd0, 5'd0, 5'd0, 32'hFFF00000, 1'b0, 32'h8000006F};
        vecs[15] = '{3'd4, 7'h6F, 3'd0, 5'd0, 5'd0, 5'd0, 32'h00100000, 1'b1, 32'h0};
        vecs[16] = '{3'd6, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 32'd0,        1'b1, 32'h0};
        vecs[17] = '{3'd7, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 32'd0,        1'b1, 32'h0};
        vecs[18] = '{3'd5, 7'h00, 3'd0, 5'd1, 5'd0, 5'd0, 32'd100,      ~LI_ON, 32'h06400093};
        vecs[19] = '{3'd5, 7'h00, 3'd0, 5'd2, 5'd0, 5'd0, 32'h12345000, ~LI_ON, 32'h12345137};
        vecs[20] = '{3'd5, 7'h00, 3'd0, 5'd3, 5'd0, 5'd0, 32'hFFFFF800, ~LI_ON, 32'h80000193};

        v_li2 = '{3'd5, 7'h00, 3'd0, 5'd10, 5'd0, 5'd0, 32'h12345FFF, ~LI_ON, 32'h12346537};
        v_j   = vecs[12];
        v_u   = vecs[10];

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst.valid", {31'd0, bus.instr_valid}, 32'd0);
        check("rst.out",   bus.instr_out,            32'd0);
        check("rst.last",  {31'd0, bus.instr_last},  32'd0);
        check("rst.err",   {31'd0, bus.err},         32'd0);
        check("rst.ready", {31'd0, bus.req_ready},   32'd0);
        reset = 1'b0;

        // Back-to-back table at full rate
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            if (i > 0) check_out(vecs[i-1], $sformatf("vec%0d", i-1));
            drive(vecs[i]);
            #1;
            check($sformatf("vec%0d.rdy", i), {31'd0, bus.req_ready}, 32'd1);
        end
        @(negedge clk);
        check_out(vecs[NV-1], $sformatf("vec%0d", NV-1));
        bus.req_valid = 1'b0;
        @(negedge clk);
        check("drain.valid", {31'd0, bus.instr_valid}, 32'd0);

        // Backpressure on a single word, then coincident handshake + accept
        bus.instr_ready = 1'b0;
        drive(v_u);
        @(negedge clk);
        drive(v_j);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("bp%0d.valid", k), {31'd0, bus.instr_valid}, 32'd1);
            check($sformatf("bp%0d.word", k),  bus.instr_out,            v_u.word);
            check($sformatf("bp%0d.rdy", k),   {31'd0, bus.req_ready},   32'd0);
            @(negedge clk);
        end
        bus.instr_ready = 1'b1;
        #1;
        check("bp.rdy_rel", {31'd0, bus.req_ready}, 32'd1);
        @(negedge clk);
        bus.req_valid = 1'b0;
        check_out(v_j, "bp.next");
        @(negedge clk);
        check("bp.drain", {31'd0, bus.instr_valid}, 32'd0);

        // Two-word LI under backpressure
        bus.instr_ready = 1'b0;
        drive(v_li2);
        @(negedge clk);
        bus.req_valid = 1'b0;
        if (LI_ON) begin
            for (int k = 0; k < 3; k++) begin
                check($sformatf("li%0d.word", k), bus.instr_out,           32'h12346537);
                check($sformatf("li%0d.last", k), {31'd0, bus.instr_last}, 32'd0);
                check($sformatf("li%0d.rdy", k),  {31'd0, bus.req_ready},  32'd0);
                @(negedge clk);
            end
            bus.instr_ready = 1'b1;
            @(negedge clk);
            check("li.lo.valid", {31'd0, bus.instr_valid}, 32'd1);
            check("li.lo.word",  bus.instr_out,            32'hFFF50513);
            check("li.lo.last",  {31'd0, bus.instr_last},  32'd1);
            @(negedge clk);
            check("li.drain", {31'd0, bus.instr_valid}, 32'd0);

            // Full-rate pair: ADDI directly after LUI
            drive(v_li2);
            @(negedge clk);
            bus.req_valid = 1'b0;
            check("lif.hi.word", bus.instr_out, 32'h12346537);
            @(negedge clk);
            check("lif.lo.valid", {31'd0, bus.instr_valid}, 32'd1);
            check("lif.lo.word",  bus.instr_out,            32'hFFF50513);
            @(negedge clk);
        end else begin
            check("li.err",   {31'd0, bus.err},         32'd1);
            check("li.valid", {31'd0, bus.instr_valid}, 32'd0);
            bus.instr_ready = 1'b1;
            @(negedge clk);
        end

        // Reset while a word (LUI of a pair when LI is built in) is pending
        bus.instr_ready = 1'b0;
        if (LI_ON) drive(v_li2);
        else       drive(v_u);
        @(negedge clk);
        bus.req_valid = 1'b0;
        check("mid.valid", {31'd0, bus.instr_valid}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        bus.instr_ready = 1'b1;
        check("mid.rst.valid", {31'd0, bus.instr_valid}, 32'd0);
        check("mid.rst.err",   {31'd0, bus.err},         32'd0);
        #1;
        check("mid.rst.rdy",   {31'd0, bus.req_ready},   32'd1);
        drive(v_j);
        @(negedge clk);
        bus.req_valid = 1'b0;
        check_out(v_j, "mid.after");
        @(negedge clk);
        check("mid.drain", {31'd0, bus.instr_valid}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end
endmodule

`default_nettype wire
